// File: rtl/nv_clk_gate_ctrl_multi.sv
// Multi-channel power clock-gating controller: each channel gates its own branch of clk
// after an idle-hysteresis window and reports ready once its wake latency has elapsed.
module nv_clk_gate_ctrl_multi #(
  parameter int NUM_CH    = 4,
  parameter int HYST_W    = 8,
  parameter int WAKE_LAT  = 2,
  parameter bit BYPASS_CG = 1'b0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cfg_global_en,
  input  logic [HYST_W-1:0] cfg_hyst,
  input  logic [NUM_CH-1:0] cfg_force_on,
  input  logic [NUM_CH-1:0] ch_busy,
  input  logic [NUM_CH-1:0] ch_wake_req,
  output logic [NUM_CH-1:0] clk_gated,
  output logic [NUM_CH-1:0] ch_clk_en,
  output logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] sts_gated
);

  localparam int CNT_W = (HYST_W > 4) ? HYST_W : 4;
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_LAT) - CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HYST  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  // Output triple {clk_en, ready, gated} as a pure function of the state being entered
  function automatic logic [2:0] decode_state(input state_e s);
    case (s)
      ST_RUN:   decode_state = 3'b110;
      ST_HYST:  decode_state = 3'b110;
      ST_GATED: decode_state = 3'b001;
      ST_WAKE:  decode_state = 3'b100;
      default:  decode_state = 3'b110;
    endcase
  endfunction

  logic [CNT_W-1:0] w_hyst_load;
  logic             w_hyst_zero;

  assign w_hyst_load = CNT_W'(cfg_hyst) - CNT_W'(1);
  assign w_hyst_zero = (cfg_hyst == '0);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_en;
    logic             r_ready;
    logic             r_gated;
    logic             w_idle;

    assign w_idle = ~ch_busy[g] & ~ch_wake_req[g] & ~cfg_force_on[g] & cfg_global_en;

    // Channel FSM; outputs are registered together with the state they decode
    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        r_state                        <= ST_RUN;
        r_cnt                          <= '0;
        {r_clk_en, r_ready, r_gated}   <= decode_state(ST_RUN);
      end else begin
        case (r_state)
          ST_RUN: begin
            if (!w_idle) begin
              r_state                      <= ST_RUN;
              {r_clk_en, r_ready, r_gated} <= decode_state(ST_RUN);
            end else if (w_hyst_zero) begin
              r_state                      <= ST_GATED;
              {r_clk_en, r_ready, r_gated} <= decode_state(ST_GATED);
            end else begin
              r_state                      <= ST_HYST;
              r_cnt                        <= w_hyst_load;
              {r_clk_en, r_ready, r_gated} <= decode_state(ST_HYST);
            end
          end
          ST_HYST: begin
            if (!w_idle) begin
              r_state                      <= ST_RUN;
              {r_clk_en, r_ready, r_gated} <= decode_state(ST_RUN);
            end else if (r_cnt == '0) begin
              r_state                      <= ST_GATED;
              {r_clk_en, r_ready, r_gated} <= decode_state(ST_GATED);
            end else begin
              r_cnt                        <= r_cnt - CNT_W'(1);
            end
          end
          ST_GATED: begin
            if (!w_idle) begin
              if (WAKE_LAT == 0) begin
                r_state                      <= ST_RUN;
                {r_clk_en, r_ready, r_gated} <= decode_state(ST_RUN);
              end else begin
                r_state                      <= ST_WAKE;
                r_cnt                        <= WAKE_LOAD;
                {r_clk_en, r_ready, r_gated} <= decode_state(ST_WAKE);
              end
            end else begin
              r_state                      <= ST_GATED;
            end
          end
          // Inputs are deliberately ignored here so a channel cannot re-gate mid-wake
          ST_WAKE: begin
            if (r_cnt == '0) begin
              r_state                      <= ST_RUN;
              {r_clk_en, r_ready, r_gated} <= decode_state(ST_RUN);
            end else begin
              r_cnt                        <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state                      <= ST_RUN;
            r_cnt                        <= '0;
            {r_clk_en, r_ready, r_gated} <= decode_state(ST_RUN);
          end
        endcase
      end
    end

    assign ch_clk_en[g] = r_clk_en;
    assign ch_ready[g]  = r_ready;
    assign sts_gated[g] = r_gated;

    if (BYPASS_CG) begin : g_byp
      assign clk_gated[g] = clk;
    end else begin : g_icg
      logic r_en_lat;

      // ICG enable latch: transparent only while clk is low, so pulses are never truncated
      always_latch begin
        if (!clk) r_en_lat <= r_clk_en;
      end

      assign clk_gated[g] = clk & r_en_lat;
    end
  end

`ifndef SYNTHESIS
  nv_clk_gate_ctrl_multi_chk #(
    .NUM_CH   (NUM_CH),
    .WAKE_LAT (WAKE_LAT)
  ) u_chk (
    .clk          (clk),
    .reset_       (reset_),
    .cfg_force_on (cfg_force_on),
    .ch_busy      (ch_busy),
    .ch_wake_req  (ch_wake_req),
    .clk_gated    (clk_gated),
    .ch_ready     (ch_ready)
  );
`endif

endmodule

`ifndef SYNTHESIS
// Simulation-only checks for the gating controller; disabled by setting DISABLE_ASSERTS.
module nv_clk_gate_ctrl_multi_chk #(
  parameter int NUM_CH          = 4,
  parameter int WAKE_LAT        = 2,
  parameter bit DISABLE_ASSERTS = 1'b0
) (
  input logic              clk,
  input logic              reset_,
  input logic [NUM_CH-1:0] cfg_force_on,
  input logic [NUM_CH-1:0] ch_busy,
  input logic [NUM_CH-1:0] ch_wake_req,
  input logic [NUM_CH-1:0] clk_gated,
  input logic [NUM_CH-1:0] ch_ready
);

  localparam int STALL_MAX = WAKE_LAT + 1;

  logic [4:0] r_stall [NUM_CH];

  // Consecutive cycles each channel has been busy without a usable clock
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NUM_CH; i++) r_stall[i] <= 5'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_busy[i] && !ch_ready[i]) begin
          if (r_stall[i] != 5'd31) r_stall[i] <= r_stall[i] + 5'd1;
          else                     r_stall[i] <= r_stall[i];
        end else begin
          r_stall[i] <= 5'd0;
        end
      end
    end
  end

  // Sampled sanity checks outside reset
  always @(posedge clk) begin
    if (reset_ && !DISABLE_ASSERTS) begin
      a_gclk_known: assert (!$isunknown(clk_gated));
      a_in_known:   assert (!$isunknown({ch_busy, ch_wake_req, cfg_force_on}));
      for (int i = 0; i < NUM_CH; i++) begin
        assert (r_stall[i] <= 5'(STALL_MAX));
      end
    end
  end

endmodule
`endif

// File: tb/tb_nv_clk_gate_ctrl_multi.sv
// Bench for nv_clk_gate_ctrl_multi: gated and bypass builds side by side, checked against
// an idle-run / wake-countdown reference model with directed scenarios and random traffic.
module tb_nv_clk_gate_ctrl_multi;

  localparam int NUM_CH   = 4;
  localparam int HYST_W   = 8;
  localparam int WAKE_LAT = 2;

  logic              clk           = 1'b0;
  logic              reset_        = 1'b1;
  logic              cfg_global_en = 1'b1;
  logic [HYST_W-1:0] cfg_hyst      = 8'd3;
  logic [NUM_CH-1:0] cfg_force_on  = 4'h0;
  logic [NUM_CH-1:0] ch_busy       = 4'h0;
  logic [NUM_CH-1:0] ch_wake_req   = 4'h0;

  logic [NUM_CH-1:0] clk_gated, ch_clk_en, ch_ready, sts_gated;
  logic [NUM_CH-1:0] b_clk_gated, b_ch_clk_en, b_ch_ready, b_sts_gated;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: gated flag, remaining wake cycles, idle run length, latched threshold
  bit m_gated [NUM_CH];
  int m_wake  [NUM_CH];
  int m_run   [NUM_CH];
  int m_hlat  [NUM_CH];
  logic [NUM_CH-1:0] prev_en;

  always #5 clk = ~clk;

  nv_clk_gate_ctrl_multi #(.NUM_CH(NUM_CH), .HYST_W(HYST_W), .WAKE_LAT(WAKE_LAT), .BYPASS_CG(1'b0)) dut (
    .clk(clk), .reset_(reset_), .cfg_global_en(cfg_global_en), .cfg_hyst(cfg_hyst),
    .cfg_force_on(cfg_force_on), .ch_busy(ch_busy), .ch_wake_req(ch_wake_req),
    .clk_gated(clk_gated), .ch_clk_en(ch_clk_en), .ch_ready(ch_ready), .sts_gated(sts_gated)
  );

  nv_clk_gate_ctrl_multi #(.NUM_CH(NUM_CH), .HYST_W(HYST_W), .WAKE_LAT(WAKE_LAT), .BYPASS_CG(1'b1)) dut_byp (
    .clk(clk), .reset_(reset_), .cfg_global_en(cfg_global_en), .cfg_hyst(cfg_hyst),
    .cfg_force_on(cfg_force_on), .ch_busy(ch_busy), .ch_wake_req(ch_wake_req),
    .clk_gated(b_clk_gated), .ch_clk_en(b_ch_clk_en), .ch_ready(b_ch_ready), .sts_gated(b_sts_gated)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_gated[i] = 1'b0;
      m_wake[i]  = 0;
      m_run[i]   = 0;
      m_hlat[i]  = 0;
    end
  endtask

  // Gating happens after cfg_hyst+1 consecutive idle edges; wake takes WAKE_LAT further edges
  task automatic model_edge();
    logic idle;
    for (int i = 0; i < NUM_CH; i++) begin
      idle = !ch_busy[i] && !ch_wake_req[i] && !cfg_force_on[i] && cfg_global_en;
      if (m_gated[i]) begin
        if (!idle) begin
          m_gated[i] = 1'b0;
          m_wake[i]  = WAKE_LAT;
        end
      end else if (m_wake[i] > 0) begin
        m_wake[i]--;
      end else if (idle) begin
        if (m_run[i] == 0) m_hlat[i] = int'(cfg_hyst);
        m_run[i]++;
        if (m_run[i] > m_hlat[i]) begin
          m_gated[i] = 1'b1;
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_en();
    for (int i = 0; i < NUM_CH; i++) exp_en[i] = !m_gated[i];
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ready();
    for (int i = 0; i < NUM_CH; i++) exp_ready[i] = !m_gated[i] && (m_wake[i] == 0);
  endfunction

  function automatic logic [NUM_CH-1:0] exp_sts();
    for (int i = 0; i < NUM_CH; i++) exp_sts[i] = m_gated[i];
  endfunction

  // One clock: compare after the rising edge, then check the low phase of the gated clocks
  task automatic step();
    prev_en = exp_en();
    @(posedge clk);
    if (reset_) model_edge();
    #1;
    chk("clk_en",      ch_clk_en,   exp_en());
    chk("ready",       ch_ready,    exp_ready());
    chk("sts_gated",   sts_gated,   exp_sts());
    chk("gclk_hi",     clk_gated,   prev_en);
    chk("byp_clk_en",  b_ch_clk_en, exp_en());
    chk("byp_ready",   b_ch_ready,  exp_ready());
    chk("byp_sts",     b_sts_gated, exp_sts());
    chk("byp_gclk_hi", b_clk_gated, {NUM_CH{1'b1}});
    @(negedge clk);
    #1;
    chk("gclk_lo",     clk_gated,   {NUM_CH{1'b0}});
    chk("byp_gclk_lo", b_clk_gated, {NUM_CH{1'b0}});
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 reset_ = 1'b0;
    repeat (3) step();
    chk("rst_en", ch_clk_en, 4'hF);
    reset_ = 1'b1;

    // Auto-gating after release with cfg_hyst=3
    repeat (3) step();
    chk("s1_not_yet", sts_gated, 4'h0);
    step();
    chk("s1_gated4", sts_gated, 4'hF);
    step();

    // One-cycle wake pulse on channel 1
    ch_wake_req = 4'b0010;
    step();
    ch_wake_req = 4'b0000;
    chk("s2_en",    ch_clk_en, 4'b0010);
    chk("s2_rdy0",  ch_ready,  4'b0000);
    step();
    chk("s2_rdy1",  ch_ready,  4'b0000);
    step();
    chk("s2_rdy2",  ch_ready,  4'b0010);
    step();
    chk("s2_others", sts_gated, 4'b1101);

    // Hysteresis of 5: four idle cycles must not gate, six must
    cfg_hyst = 8'd5;
    ch_busy  = 4'hF;
    repeat (4) step();
    ch_busy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("s3_en0_hold", ch_clk_en[0], 1'b1);
    end
    ch_busy[0] = 1'b1;
    step();
    ch_busy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s3_not_gated", sts_gated[0], 1'b0);
    end
    step();
    chk("s3_gate6", sts_gated[0], 1'b1);

    // Zero hysteresis and a forced-on channel
    cfg_hyst = 8'd0;
    ch_busy  = 4'hF;
    repeat (3) step();
    cfg_force_on = 4'b0100;
    ch_busy      = 4'h0;
    step();
    chk("s4_gate_next", sts_gated, 4'b1011);
    for (int k = 0; k < 100; k++) begin
      step();
      chk("s4_force_on", ch_clk_en[2], 1'b1);
    end
    cfg_force_on = 4'h0;

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      ch_busy       = 4'($urandom) & 4'($urandom);
      ch_wake_req   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      cfg_force_on  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      cfg_global_en = ($urandom_range(0, 19) != 0);
      cfg_hyst      = 8'($urandom_range(0, 4));
      step();
    end

    // Global enable drop from all-gated, then async reset mid-wake
    ch_busy       = 4'h0;
    ch_wake_req   = 4'h0;
    cfg_force_on  = 4'h0;
    cfg_global_en = 1'b1;
    cfg_hyst      = 8'd0;
    repeat (8) step();
    chk("s6_all_gated", sts_gated, 4'hF);
    cfg_global_en = 1'b0;
    step();
    chk("s6_wake_en",  ch_clk_en, 4'hF);
    chk("s6_wake_rdy", ch_ready,  4'h0);
    step();
    step();
    chk("s6_ready", ch_ready, 4'hF);
    cfg_global_en = 1'b1;
    repeat (4) step();
    chk("s6_regated", sts_gated, 4'hF);
    cfg_global_en = 1'b0;
    step();
    reset_ = 1'b0;
    model_reset();
    #1;
    chk("s6_async_rdy", ch_ready,  4'hF);
    chk("s6_async_en",  ch_clk_en, 4'hF);
    chk("s6_async_sts", sts_gated, 4'h0);
    repeat (2) step();
    reset_ = 1'b1;
    cfg_global_en = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
